// File: rtl/stopwatch_core_pkg.sv
// Shared types and constant helpers for the MM:SS stopwatch datapath.
// Field limits are held in BCD so the counters never need a binary intermediate.
package sw_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PAUSED  = 2'd1,
    ADJUST  = 2'd2,
    DONE_ST = 2'd3
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  // Elaboration-time conversion of a 0..99 integer into {tens, ones} BCD.
  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Control/status bundle between the clock divider, the stopwatch core and the display mux.
interface stopwatch_core_if;
  logic        TICK_1HZ;
  logic        TICK_ADJ;
  logic        CLEAR;
  logic        PAUSE;
  logic        ADJ;
  logic        SEL;
  logic        DOWN;
  logic [15:0] DIGITS;
  logic        RUNNING;
  logic        ROLLOVER;
  logic        DONE;
  logic [1:0]  BLINK_SEL;

  modport master (
    output TICK_1HZ, TICK_ADJ, CLEAR, PAUSE, ADJ, SEL, DOWN,
    input  DIGITS, RUNNING, ROLLOVER, DONE, BLINK_SEL
  );

  modport slave (
    input  TICK_1HZ, TICK_ADJ, CLEAR, PAUSE, ADJ, SEL, DOWN,
    output DIGITS, RUNNING, ROLLOVER, DONE, BLINK_SEL
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-(MAX+1) counter with load-to-preset, freeze, increment and decrement.
// carry_out/borrow_out flag the wrap that the current inc/dec request would cause.
module bcd_mod_counter
  import sw_pkg::*;
#(
  parameter int MAX    = 59,
  parameter int PRESET = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic hold,
  input  logic inc,
  input  logic dec,
  output bcd_t tens,
  output bcd_t ones,
  output logic at_zero,
  output logic carry_out,
  output logic borrow_out
);

  localparam logic [7:0] MAX_BCD = to_bcd2(MAX);
  localparam logic [7:0] PRE_BCD = to_bcd2(PRESET);
  localparam bcd_t MAX_TENS = MAX_BCD[7:4];
  localparam bcd_t MAX_ONES = MAX_BCD[3:0];
  localparam bcd_t PRE_TENS = PRE_BCD[7:4];
  localparam bcd_t PRE_ONES = PRE_BCD[3:0];

  bcd_t tens_r;
  bcd_t ones_r;
  bcd_t tens_nx_s;
  bcd_t ones_nx_s;
  logic at_max_s;

  assign at_zero    = (tens_r == 4'd0) && (ones_r == 4'd0);
  assign at_max_s   = (tens_r == MAX_TENS) && (ones_r == MAX_ONES);
  assign carry_out  = inc & at_max_s;
  assign borrow_out = dec & at_zero;
  assign tens       = tens_r;
  assign ones       = ones_r;

  // Next value: load beats hold beats inc beats dec; wraps never carry in from outside.
  always_comb begin
    tens_nx_s = tens_r;
    ones_nx_s = ones_r;
    if (load) begin
      tens_nx_s = PRE_TENS;
      ones_nx_s = PRE_ONES;
    end else if (hold) begin
      tens_nx_s = tens_r;
      ones_nx_s = ones_r;
    end else if (inc) begin
      if (at_max_s) begin
        tens_nx_s = 4'd0;
        ones_nx_s = 4'd0;
      end else if (ones_r == 4'd9) begin
        tens_nx_s = tens_r + 4'd1;
        ones_nx_s = 4'd0;
      end else begin
        ones_nx_s = ones_r + 4'd1;
      end
    end else if (dec) begin
      if (at_zero) begin
        tens_nx_s = MAX_TENS;
        ones_nx_s = MAX_ONES;
      end else if (ones_r == 4'd0) begin
        tens_nx_s = tens_r - 4'd1;
        ones_nx_s = 4'd9;
      end else begin
        ones_nx_s = ones_r - 4'd1;
      end
    end else begin
      tens_nx_s = tens_r;
      ones_nx_s = ones_r;
    end
  end

  // Digit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_r <= PRE_TENS;
      ones_r <= PRE_ONES;
    end else begin
      tens_r <= tens_nx_s;
      ones_r <= ones_nx_s;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch/timer: run/pause/adjust/done FSM, PAUSE edge detect and output flags.
// Seconds and minutes are two cascaded BCD counters; the seconds wrap drives the minutes.
module stopwatch_core
  import sw_pkg::*;
#(
  parameter int MIN_MAX    = 59,
  parameter int SEC_MAX    = 59,
  parameter int PRESET_MIN = 0,
  parameter int PRESET_SEC = 0
) (
  input  logic             clk,
  input  logic             RESET_N,
  stopwatch_core_if.slave  sw
);

  sw_state_t state_r;
  sw_state_t state_nx_s;
  logic      pause_q_r;
  logic      pause_rise_s;
  logic      roll_r;
  logic      roll_nx_s;
  logic      done_r;
  logic      done_nx_s;
  logic      count_up_s;
  logic      down_req_s;
  logic      adj_sec_s;
  logic      adj_min_s;
  logic      freeze_s;

  logic sec_inc_s, sec_dec_s, sec_at_zero_s, sec_carry_s, sec_borrow_s;
  logic min_inc_s, min_dec_s, min_at_zero_s, min_carry_s, min_borrow_s;
  bcd_t sec_tens_s, sec_ones_s, min_tens_s, min_ones_s;

  assign pause_rise_s = sw.PAUSE & ~pause_q_r;

  // State transitions in priority order: clear, adjust entry/exit, pause toggle, count.
  always_comb begin
    state_nx_s = state_r;
    done_nx_s  = done_r;
    count_up_s = 1'b0;
    down_req_s = 1'b0;
    adj_sec_s  = 1'b0;
    adj_min_s  = 1'b0;
    if (sw.CLEAR) begin
      state_nx_s = RUN;
      done_nx_s  = 1'b0;
    end else if (((state_r == RUN) || (state_r == PAUSED)) && sw.ADJ) begin
      state_nx_s = ADJUST;
    end else if (state_r == ADJUST) begin
      if (!sw.ADJ) begin
        state_nx_s = PAUSED;
      end else if (sw.TICK_ADJ) begin
        adj_min_s = sw.SEL;
        adj_sec_s = ~sw.SEL;
      end else begin
        state_nx_s = ADJUST;
      end
    end else if ((state_r == RUN) && pause_rise_s) begin
      state_nx_s = PAUSED;
    end else if ((state_r == PAUSED) && pause_rise_s) begin
      state_nx_s = RUN;
    end else if ((state_r == RUN) && sw.TICK_1HZ) begin
      if (sw.DOWN) begin
        down_req_s = 1'b1;
        if (sec_at_zero_s && min_at_zero_s) begin
          state_nx_s = DONE_ST;
          done_nx_s  = 1'b1;
        end else begin
          state_nx_s = RUN;
        end
      end else begin
        count_up_s = 1'b1;
      end
    end else begin
      state_nx_s = state_r;
    end
  end

  // A down tick at 00:00 would borrow out of the minutes; that same borrow freezes both fields.
  assign sec_inc_s = count_up_s | adj_sec_s;
  assign sec_dec_s = down_req_s;
  assign min_inc_s = adj_min_s | sec_carry_s;
  assign min_dec_s = sec_borrow_s;
  assign freeze_s  = min_borrow_s;
  assign roll_nx_s = sec_carry_s & min_carry_s;

  bcd_mod_counter #(.MAX(SEC_MAX), .PRESET(PRESET_SEC)) u_sec (
    .clk        (clk),
    .rst_n      (RESET_N),
    .load       (sw.CLEAR),
    .hold       (freeze_s),
    .inc        (sec_inc_s),
    .dec        (sec_dec_s),
    .tens       (sec_tens_s),
    .ones       (sec_ones_s),
    .at_zero    (sec_at_zero_s),
    .carry_out  (sec_carry_s),
    .borrow_out (sec_borrow_s)
  );

  bcd_mod_counter #(.MAX(MIN_MAX), .PRESET(PRESET_MIN)) u_min (
    .clk        (clk),
    .rst_n      (RESET_N),
    .load       (sw.CLEAR),
    .hold       (freeze_s),
    .inc        (min_inc_s),
    .dec        (min_dec_s),
    .tens       (min_tens_s),
    .ones       (min_ones_s),
    .at_zero    (min_at_zero_s),
    .carry_out  (min_carry_s),
    .borrow_out (min_borrow_s)
  );

  // State, PAUSE history and flag registers.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r   <= RUN;
      pause_q_r <= 1'b0;
      roll_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      pause_q_r <= sw.PAUSE;
      roll_r    <= roll_nx_s;
      done_r    <= done_nx_s;
    end
  end

  // Blink indication tracks SEL live while adjusting.
  always_comb begin
    sw.BLINK_SEL = 2'b00;
    if (state_r == ADJUST) begin
      sw.BLINK_SEL = sw.SEL ? 2'b10 : 2'b01;
    end else begin
      sw.BLINK_SEL = 2'b00;
    end
  end

  assign sw.DIGITS   = {min_tens_s, min_ones_s, sec_tens_s, sec_ones_s};
  assign sw.RUNNING  = (state_r == RUN);
  assign sw.ROLLOVER = roll_r;
  assign sw.DONE     = done_r;

endmodule
